icache_responder: RTL



---
 rtl/icache_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache (16-byte lines) returning the 32-bit window at any halfword PC.
// Optional performance counters are built when ICACHE_PERF_EN is defined.
module icache_responder #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        to_icache,
   input  logic [31:0] pc_to_icache,
   output logic        have_result,
   output logic [31:0] inst_from_icache,
   output logic        mc_req,
   output logic [31:0] mc_addr,
   input  logic        mc_valid,
   input  logic [31:0] mc_data,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   // state    | meaning
   // S_IDLE   | waiting for a fetch request; resident windows answered here
   // S_FILL   | streaming four beats of one line from the memory controller
   // S_LOOKUP | re-checking the latched PC after a fill completes

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 28 - INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_LOOKUP = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [127:0]      data_q [LINES];
   logic [31:1]       pc_q;
   logic [1:0]        beat_q;
   logic [27:0]       fill_line_q;
   logic              have_result_q;
   logic [31:0]       inst_q;

   logic [31:1]           eval_pc;
   logic [27:0]           line0, line1, miss_line;
   logic [INDEX_BITS-1:0] idx0, idx1, fill_idx, miss_idx;
   logic                  hit0, hit1;
   logic [2:0]            hw_off;
   logic [127:0]          data0, data1;
   logic [15:0]           win_lo, win_hi;
   logic                  resident;
   logic                  respond, start_fill, beat_in;

   logic unused_pc0;
   assign unused_pc0 = pc_to_icache[0];

   // IDLE looks at the live request; LOOKUP re-examines the latched one
   assign eval_pc  = (state_q == S_IDLE) ? pc_to_icache[31:1] : pc_q;
   assign line0    = eval_pc[31:4];
   assign line1    = line0 + 28'd1;
   assign idx0     = line0[INDEX_BITS-1:0];
   assign idx1     = line1[INDEX_BITS-1:0];
   assign hit0     = valid_q[idx0] && (tag_q[idx0] == line0[27:INDEX_BITS]);
   assign hit1     = valid_q[idx1] && (tag_q[idx1] == line1[27:INDEX_BITS]);
   assign hw_off   = eval_pc[3:1];
   assign data0    = data_q[idx0];
   assign data1    = data_q[idx1];
   assign fill_idx = fill_line_q[INDEX_BITS-1:0];
   assign miss_idx = miss_line[INDEX_BITS-1:0];
   assign beat_in  = (state_q == S_FILL) && mc_valid;

   // A compressed halfword at offset 7 never needs the following line
   always_comb begin
      win_lo    = data0[{hw_off, 4'b0000} +: 16];
      win_hi    = '0;
      resident  = hit0;
      miss_line = line0;
      if (hw_off != 3'd7) begin
         win_hi = data0[{hw_off + 3'd1, 4'b0000} +: 16];
      end else if (win_lo[1:0] == 2'b11) begin
         win_hi   = data1[15:0];
         resident = hit0 && hit1;
         if (hit0) miss_line = line1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= S_IDLE;
      else if (rdy_in) state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      respond    = 1'b0;
      start_fill = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (to_icache) begin
               if (resident) begin
                  respond = 1'b1;
               end else begin
                  start_fill = 1'b1;
                  state_d    = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (mc_valid && (beat_q == 2'd3)) state_d = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (resident) begin
               respond = 1'b1;
               state_d = S_IDLE;
            end else begin
               start_fill = 1'b1;
               state_d    = S_FILL;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q       <= '0;
         pc_q          <= '0;
         beat_q        <= '0;
         fill_line_q   <= '0;
         have_result_q <= 1'b0;
         inst_q        <= '0;
      end else if (rdy_in) begin
         have_result_q <= respond;
         if (respond) inst_q <= {win_hi, win_lo};
         if ((state_q == S_IDLE) && to_icache) pc_q <= pc_to_icache[31:1];
         // the victim line goes invalid until its last beat lands
         if (start_fill) begin
            fill_line_q        <= miss_line;
            valid_q[miss_idx]  <= 1'b0;
         end
         if (beat_in) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) valid_q[fill_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in && beat_in) begin
         data_q[fill_idx][{beat_q, 5'b00000} +: 32] <= mc_data;
         if (beat_q == 2'd3) tag_q[fill_idx] <= fill_line_q[27:INDEX_BITS];
      end
   end

   assign have_result      = have_result_q;
   assign inst_from_icache = inst_q;
   assign mc_req           = (state_q == S_FILL);
   assign mc_addr          = {fill_line_q, 4'b0000};

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (rdy_in) begin
         if (respond && (state_q == S_IDLE) && (hit_q != 32'hFFFF_FFFF)) hit_q <= hit_q + 32'd1;
         if (start_fill && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule
